// File: rtl/tmds_decoder.sv
// TMDS receive decoder for one channel: token/data classification, 8b recovery and lock tracking.
// Build option: define TMDS_DISPARITY_CHECK_EN to add a running-disparity monitor on err_out.
module tmds_decoder #(
    parameter int LOCK_COUNT   = 8,
    parameter int MAX_DATA_RUN = 2200,
    parameter int DISP_LIMIT   = 16
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic [9:0] tmds_in,
    output logic [7:0] data_out,
    output logic [1:0] control_out,
    output logic       ve_out,
    output logic       locked_out,
    output logic       err_out
);
    localparam int TOK_W = $clog2(LOCK_COUNT + 1);
    localparam int RUN_W = $clog2(MAX_DATA_RUN + 2);

    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_01 = 10'b0010101011;
    localparam logic [9:0] TOK_10 = 10'b0101010100;
    localparam logic [9:0] TOK_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } lock_state_t;

    logic [9:0]  tmds_q;
    logic        s1_vld_q;
    logic        s1_tok_q;
    logic [1:0]  s1_val_q;
    logic        tok_hit_d;
    logic [1:0]  tok_val_d;

    logic [7:0]  dec_x;
    logic [7:0]  dec_d;
    logic [7:0]  data_q;
    logic [1:0]  ctrl_q;
    logic        ve_q;
    logic        err_q;
    logic        err_d;

    lock_state_t      state_q, state_d;
    logic [TOK_W-1:0] tok_cnt_q, tok_cnt_d;
    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic             lock_err;
    logic             disp_err;

    always_comb begin
        tok_hit_d = 1'b1;
        tok_val_d = 2'b00;
        case (tmds_in)
            TOK_00:  tok_val_d = 2'b00;
            TOK_01:  tok_val_d = 2'b01;
            TOK_10:  tok_val_d = 2'b10;
            TOK_11:  tok_val_d = 2'b11;
            default: tok_hit_d = 1'b0;
        endcase
    end

    // s1_vld_q keeps the reset-cleared S1 contents from ever reaching the outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tmds_q   <= '0;
            s1_vld_q <= 1'b0;
            s1_tok_q <= 1'b0;
            s1_val_q <= '0;
        end else begin
            tmds_q   <= tmds_in;
            s1_vld_q <= 1'b1;
            s1_tok_q <= tok_hit_d;
            s1_val_q <= tok_val_d;
        end
    end

    always_comb begin
        dec_x    = tmds_q[9] ? ~tmds_q[7:0] : tmds_q[7:0];
        dec_d    = '0;
        dec_d[0] = dec_x[0];
        for (int i = 1; i < 8; i++) begin
            dec_d[i] = tmds_q[8] ? (dec_x[i] ^ dec_x[i-1]) : ~(dec_x[i] ^ dec_x[i-1]);
        end
    end

    always_comb begin
        state_d   = state_q;
        tok_cnt_d = tok_cnt_q;
        run_cnt_d = run_cnt_q;
        lock_err  = 1'b0;
        if (s1_vld_q) begin
            case (state_q)
                UNLOCKED: begin
                    if (s1_tok_q) begin
                        tok_cnt_d = TOK_W'(1);
                        run_cnt_d = '0;
                        state_d   = (LOCK_COUNT <= 1) ? LOCKED : LOCKING;
                    end
                end
                LOCKING: begin
                    if (s1_tok_q) begin
                        if (tok_cnt_q != TOK_W'(LOCK_COUNT)) begin
                            tok_cnt_d = tok_cnt_q + 1'b1;
                        end
                        if (tok_cnt_q >= TOK_W'(LOCK_COUNT - 1)) begin
                            state_d   = LOCKED;
                            run_cnt_d = '0;
                        end
                    end else begin
                        state_d   = UNLOCKED;
                        tok_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (s1_tok_q) begin
                        run_cnt_d = '0;
                    end else if (run_cnt_q == RUN_W'(MAX_DATA_RUN)) begin
                        state_d   = UNLOCKED;
                        tok_cnt_d = '0;
                        run_cnt_d = '0;
                        lock_err  = 1'b1;
                    end else begin
                        run_cnt_d = run_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d   = UNLOCKED;
                    tok_cnt_d = '0;
                    run_cnt_d = '0;
                end
            endcase
        end
    end

`ifdef TMDS_DISPARITY_CHECK_EN
    localparam logic signed [8:0] LIM = 9'(DISP_LIMIT);

    logic signed [7:0] acc_q, acc_d;
    logic [3:0]        ones;
    logic signed [8:0] disp;
    logic signed [8:0] sum;
    logic signed [8:0] sat;

    // Symbol disparity is ones - zeros = 2*ones - 10.
    always_comb begin
        ones = 4'($countones(tmds_q));
        disp = $signed({4'b0000, ones, 1'b0}) - 9'sd10;
        sum  = $signed({acc_q[7], acc_q}) + disp;
        if (sum > 9'sd127) begin
            sat = 9'sd127;
        end else if (sum < -9'sd127) begin
            sat = -9'sd127;
        end else begin
            sat = sum;
        end
        acc_d    = acc_q;
        disp_err = 1'b0;
        if (s1_vld_q) begin
            if (s1_tok_q) begin
                acc_d = '0;
            end else if ((state_q == LOCKED) && ((sat > LIM) || (sat < -LIM))) begin
                disp_err = 1'b1;
                acc_d    = '0;
            end else begin
                acc_d = sat[7:0];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    // No accumulator in this build; a negative limit is meaningless so this is constant 0.
    assign disp_err = (DISP_LIMIT < 0);
`endif

    assign err_d = lock_err | disp_err;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            data_q    <= '0;
            ctrl_q    <= '0;
            ve_q      <= 1'b0;
            err_q     <= 1'b0;
            state_q   <= UNLOCKED;
            tok_cnt_q <= '0;
            run_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            state_q   <= state_d;
            tok_cnt_q <= tok_cnt_d;
            run_cnt_q <= run_cnt_d;
            if (s1_vld_q) begin
                ve_q <= ~s1_tok_q;
                if (s1_tok_q) begin
                    ctrl_q <= s1_val_q;
                end else begin
                    data_q <= dec_d;
                end
            end
        end
    end

    assign data_out    = data_q;
    assign control_out = ctrl_q;
    assign ve_out      = ve_q;
    assign err_out     = err_q;
    assign locked_out  = (state_q == LOCKED);

endmodule
